// File: rtl/alu_top.sv
// Clocked 16-function ALU: one-hot unit decode on ALU_FUN[3:2], one registered result and flag per unit.
// Optional feature: define ALU_DIVIDER_EN to build the unsigned divider used by function 0011.
module alu_top #(
    parameter int INDATA_WIDTH = 16
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [INDATA_WIDTH-1:0]     A,
    input  logic [INDATA_WIDTH-1:0]     B,
    input  logic [3:0]                  ALU_FUN,
    output logic [2*INDATA_WIDTH-1:0]   Arith_OUT,
    output logic                        Carry_OUT,
    output logic                        Arith_FLAG,
    output logic [INDATA_WIDTH-1:0]     Logic_OUT,
    output logic                        Logic_FLAG,
    output logic [INDATA_WIDTH-1:0]     Shift_OUT,
    output logic                        Shift_FLAG,
    output logic [2:0]                  CMP_OUT,
    output logic                        CMP_FLAG
);

    localparam int W = INDATA_WIDTH;

    logic [3:0]     unit_en_s;     // [0] arith, [1] logic, [2] compare, [3] shift
    logic [W:0]     sum_s;
    logic [2*W-1:0] a_ext_s;
    logic [2*W-1:0] b_ext_s;
    logic [2*W-1:0] arith_res_s;
    logic           arith_carry_s;
    logic [W-1:0]   logic_res_s;
    logic [2:0]     cmp_res_s;
    logic [W-1:0]   shift_res_s;

    assign sum_s   = {1'b0, A} + {1'b0, B};
    assign a_ext_s = {{W{1'b0}}, A};
    assign b_ext_s = {{W{1'b0}}, B};

`ifdef ALU_DIVIDER_EN
    logic [W-1:0] quot_s;

    // Unsigned quotient, forced to zero on divide-by-zero
    always_comb begin
        quot_s = {W{1'b0}};
        if (B != {W{1'b0}}) begin
            quot_s = A / B;
        end else begin
            quot_s = {W{1'b0}};
        end
    end
`endif

    // One-hot unit decode
    always_comb begin
        unit_en_s = 4'b0000;
        case (ALU_FUN[3:2])
            2'b00:   unit_en_s = 4'b0001;
            2'b01:   unit_en_s = 4'b0010;
            2'b10:   unit_en_s = 4'b0100;
            2'b11:   unit_en_s = 4'b1000;
            default: unit_en_s = 4'b0000;
        endcase
    end

    // Arithmetic unit datapath; carry doubles as the borrow for subtraction
    always_comb begin
        arith_res_s   = {(2*W){1'b0}};
        arith_carry_s = 1'b0;
        case (ALU_FUN[1:0])
            2'b00: begin
                arith_res_s   = {{(W-1){1'b0}}, sum_s};
                arith_carry_s = sum_s[W];
            end
            2'b01: begin
                arith_res_s   = a_ext_s - b_ext_s;
                arith_carry_s = (A < B) ? 1'b1 : 1'b0;
            end
            2'b10: begin
                arith_res_s   = a_ext_s * b_ext_s;
                arith_carry_s = 1'b0;
            end
            2'b11: begin
`ifdef ALU_DIVIDER_EN
                arith_res_s   = {{W{1'b0}}, quot_s};
`else
                arith_res_s   = {(2*W){1'b0}};
`endif
                arith_carry_s = 1'b0;
            end
            default: begin
                arith_res_s   = {(2*W){1'b0}};
                arith_carry_s = 1'b0;
            end
        endcase
    end

    // Logic unit datapath
    always_comb begin
        logic_res_s = {W{1'b0}};
        case (ALU_FUN[1:0])
            2'b00:   logic_res_s = A & B;
            2'b01:   logic_res_s = A | B;
            2'b10:   logic_res_s = ~(A & B);
            2'b11:   logic_res_s = ~(A | B);
            default: logic_res_s = {W{1'b0}};
        endcase
    end

    // Compare unit datapath; a false relation yields zero
    always_comb begin
        cmp_res_s = 3'd0;
        case (ALU_FUN[1:0])
            2'b00:   cmp_res_s = 3'd0;
            2'b01:   cmp_res_s = (A == B) ? 3'd1 : 3'd0;
            2'b10:   cmp_res_s = (A > B)  ? 3'd2 : 3'd0;
            2'b11:   cmp_res_s = (A < B)  ? 3'd3 : 3'd0;
            default: cmp_res_s = 3'd0;
        endcase
    end

    // Shift unit datapath, logical with zero fill
    always_comb begin
        shift_res_s = {W{1'b0}};
        case (ALU_FUN[1:0])
            2'b00:   shift_res_s = A >> 1;
            2'b01:   shift_res_s = A << 1;
            2'b10:   shift_res_s = B >> 1;
            2'b11:   shift_res_s = B << 1;
            default: shift_res_s = {W{1'b0}};
        endcase
    end

    // Arithmetic result register, cleared whenever the unit is not selected
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Arith_OUT <= {(2*W){1'b0}};
            Carry_OUT <= 1'b0;
        end else if (unit_en_s[0]) begin
            Arith_OUT <= arith_res_s;
            Carry_OUT <= arith_carry_s;
        end else begin
            Arith_OUT <= {(2*W){1'b0}};
            Carry_OUT <= 1'b0;
        end
    end

    // Logic result register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Logic_OUT <= {W{1'b0}};
        end else if (unit_en_s[1]) begin
            Logic_OUT <= logic_res_s;
        end else begin
            Logic_OUT <= {W{1'b0}};
        end
    end

    // Compare result register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            CMP_OUT <= 3'd0;
        end else if (unit_en_s[2]) begin
            CMP_OUT <= cmp_res_s;
        end else begin
            CMP_OUT <= 3'd0;
        end
    end

    // Shift result register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Shift_OUT <= {W{1'b0}};
        end else if (unit_en_s[3]) begin
            Shift_OUT <= shift_res_s;
        end else begin
            Shift_OUT <= {W{1'b0}};
        end
    end

    // Unit-selected flags, exactly one high after any post-reset edge
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Arith_FLAG <= 1'b0;
            Logic_FLAG <= 1'b0;
            CMP_FLAG   <= 1'b0;
            Shift_FLAG <= 1'b0;
        end else begin
            Arith_FLAG <= unit_en_s[0];
            Logic_FLAG <= unit_en_s[1];
            CMP_FLAG   <= unit_en_s[2];
            Shift_FLAG <= unit_en_s[3];
        end
    end

endmodule

// File: tb/tb_alu_top.sv
// Randomised self-checking bench for alu_top against a behavioural model, plus pinned directed vectors.
module tb_alu_top;

    localparam int W = 16;

    logic           CLK = 1'b0;
    logic           RST = 1'b1;
    logic [W-1:0]   A = '0;
    logic [W-1:0]   B = '0;
    logic [3:0]     FUN = 4'd0;
    logic [2*W-1:0] Arith_OUT;
    logic           Carry_OUT;
    logic           Arith_FLAG;
    logic [W-1:0]   Logic_OUT;
    logic           Logic_FLAG;
    logic [W-1:0]   Shift_OUT;
    logic           Shift_FLAG;
    logic [2:0]     CMP_OUT;
    logic           CMP_FLAG;
    logic [4:0]     flags_s;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    alu_top #(.INDATA_WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(FUN),
        .Arith_OUT(Arith_OUT), .Carry_OUT(Carry_OUT), .Arith_FLAG(Arith_FLAG),
        .Logic_OUT(Logic_OUT), .Logic_FLAG(Logic_FLAG),
        .Shift_OUT(Shift_OUT), .Shift_FLAG(Shift_FLAG),
        .CMP_OUT(CMP_OUT), .CMP_FLAG(CMP_FLAG)
    );

    assign flags_s = {Carry_OUT, Arith_FLAG, Logic_FLAG, CMP_FLAG, Shift_FLAG};

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [2*W-1:0] arith;
        logic [W-1:0]   lg;
        logic [2:0]     cmp;
        logic [W-1:0]   sh;
        logic [4:0]     flags;
    } res_t;

    res_t exp_r = '0;

    function automatic res_t model(input logic [3:0] f, input logic [W-1:0] av, input logic [W-1:0] bv);
        res_t r;
        longint unsigned a, b, v, m1, m2;
        int unit, op;
        r = '0;
        a = av; b = bv;
        m1 = (64'd1 << W) - 64'd1;
        m2 = (64'd1 << (2 * W)) - 64'd1;
        unit = int'(f) / 4;
        op = int'(f) % 4;
        v = 64'd0;
        if (unit == 0) begin
            r.flags = 5'b01000;
            if (op == 0) begin
                v = a + b;
                if (v > m1) r.flags = 5'b11000;
            end else if (op == 1) begin
                v = (a - b) & m2;
                if (a < b) r.flags = 5'b11000;
            end else if (op == 2) begin
                v = a * b;
            end else begin
`ifdef ALU_DIVIDER_EN
                v = (b != 0) ? a / b : 64'd0;
`else
                v = 64'd0;
`endif
            end
            r.arith = v[2*W-1:0];
        end else if (unit == 1) begin
            r.flags = 5'b00100;
            if (op == 0)      v = a & b;
            else if (op == 1) v = a | b;
            else if (op == 2) v = ~(a & b) & m1;
            else              v = ~(a | b) & m1;
            r.lg = v[W-1:0];
        end else if (unit == 2) begin
            r.flags = 5'b00010;
            if (op == 1 && a == b)     r.cmp = 3'd1;
            else if (op == 2 && a > b) r.cmp = 3'd2;
            else if (op == 3 && a < b) r.cmp = 3'd3;
            else                       r.cmp = 3'd0;
        end else begin
            r.flags = 5'b00001;
            if (op == 0)      v = a >> 1;
            else if (op == 1) v = (a << 1) & m1;
            else if (op == 2) v = b >> 1;
            else              v = (b << 1) & m1;
            r.sh = v[W-1:0];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: one-cycle latency, asynchronous clear
    always @(posedge CLK or negedge RST) begin
        if (!RST) exp_r <= '0;
        else      exp_r <= model(FUN, A, B);
    end

    // Every-cycle comparison on the falling edge
    always @(negedge CLK) begin
        if (chk_en) begin
            check("arith", {32'd0, Arith_OUT}, {32'd0, exp_r.arith});
            check("logic", {48'd0, Logic_OUT}, {48'd0, exp_r.lg});
            check("cmp",   {61'd0, CMP_OUT},   {61'd0, exp_r.cmp});
            check("shift", {48'd0, Shift_OUT}, {48'd0, exp_r.sh});
            check("flags", {59'd0, flags_s},   {59'd0, exp_r.flags});
        end
    end

    task automatic vec(input string name, input logic [3:0] f, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [63:0] expv, input logic [4:0] expf);
        logic [63:0] act;
        @(negedge CLK);
        #1;
        FUN = f; A = av; B = bv;
        @(posedge CLK);
        #1;
        case (f[3:2])
            2'b00:   act = {32'd0, Arith_OUT};
            2'b01:   act = {48'd0, Logic_OUT};
            2'b10:   act = {61'd0, CMP_OUT};
            default: act = {48'd0, Shift_OUT};
        endcase
        check(name, act, expv);
        check({name, "_flags"}, {59'd0, flags_s}, {59'd0, expf});
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_arith"}, {32'd0, Arith_OUT}, 64'd0);
        check({name, "_logic"}, {48'd0, Logic_OUT}, 64'd0);
        check({name, "_cmp"},   {61'd0, CMP_OUT},   64'd0);
        check({name, "_shift"}, {48'd0, Shift_OUT}, 64'd0);
        check({name, "_flags"}, {59'd0, flags_s},   64'd0);
    endtask

    initial begin
        logic [63:0] div_exp;
`ifdef ALU_DIVIDER_EN
        div_exp = 64'd1;
`else
        div_exp = 64'd0;
`endif
        #1 RST = 1'b0;
        #1 chk_en = 1'b1;
        A = 16'd15; B = 16'd10; FUN = 4'b0000;
        check_all_zero("rst_pre");
        repeat (2) @(posedge CLK);
        #1 check_all_zero("rst_post");
        @(negedge CLK);
        RST = 1'b1;

        vec("add",      4'b0000, 16'd15, 16'd10, 64'd25, 5'b01000);
        vec("sub",      4'b0001, 16'd15, 16'd10, 64'd5,  5'b01000);
        vec("mul",      4'b0010, 16'd2,  16'd2,  64'd4,  5'b01000);
        vec("div",      4'b0011, 16'd2,  16'd2,  div_exp, 5'b01000);
        vec("div0",     4'b0011, 16'd2,  16'd0,  64'd0,  5'b01000);
        vec("add_ovf",  4'b0000, 16'hFFFF, 16'hFFFF, 64'h1FFFE, 5'b11000);
        vec("sub_brw",  4'b0001, 16'd2,  16'd3,  64'hFFFF_FFFF, 5'b11000);
        vec("and",      4'b0100, 16'd2,  16'd2,  64'd2,  5'b00100);
        vec("or",       4'b0101, 16'd3,  16'd2,  64'd3,  5'b00100);
        vec("nand",     4'b0110, 16'd1,  16'd1,  64'hFFFE, 5'b00100);
        vec("nor",      4'b0111, 16'd1,  16'd1,  64'hFFFE, 5'b00100);
        vec("cmp0",     4'b1000, 16'd1,  16'd1,  64'd0,  5'b00010);
        vec("cmp_eq",   4'b1001, 16'd1,  16'd1,  64'd1,  5'b00010);
        vec("cmp_gt",   4'b1010, 16'd3,  16'd2,  64'd2,  5'b00010);
        vec("cmp_lt",   4'b1011, 16'd2,  16'd3,  64'd3,  5'b00010);
        vec("cmp_lt_f", 4'b1011, 16'd3,  16'd2,  64'd0,  5'b00010);
        vec("shr_a",    4'b1100, 16'd2,  16'd7,  64'd1,  5'b00001);
        vec("shl_a",    4'b1101, 16'd2,  16'd7,  64'd4,  5'b00001);
        vec("shr_b",    4'b1110, 16'd7,  16'd2,  64'd1,  5'b00001);
        vec("shl_b",    4'b1111, 16'd7,  16'd2,  64'd4,  5'b00001);
        vec("shl_msb",  4'b1101, 16'h8000, 16'd0, 64'd0, 5'b00001);
        vec("shl_live", 4'b1101, 16'd2,  16'd0,  64'd4,  5'b00001);

        // Mid-cycle asynchronous reset while Shift_OUT is non-zero
        #2 RST = 1'b0;
        #1 check_all_zero("async_rst");
        @(negedge CLK);
        #1 RST = 1'b1;

        repeat (400) begin
            @(negedge CLK);
            #1;
            FUN = 4'($urandom_range(0, 15));
            A = 16'($urandom);
            case ($urandom_range(0, 5))
                0:       B = 16'd0;
                1:       B = A;
                2:       begin A = 16'hFFFF; B = 16'($urandom); end
                default: B = 16'($urandom);
            endcase
        end
        @(negedge CLK);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_top.md
Name: alu_top

Overview:
- Clocked 16-function ALU, parameterised operand width; sits as a standalone datapath block fed by a controller issuing ALU_FUN each cycle.
- A 2-bit decoder on ALU_FUN[3:2] enables exactly one of four units: arithmetic, logic, compare or shift.
- Each unit has its own registered result and a registered "valid/selected" flag.
- Disabled units drive zero.

Parameters:
- INDATA_WIDTH, default 16: width W of operands A and B; arithmetic result is 2W wide.

Ports:
- CLK  in  1  clock; all outputs update on rising edge
- RST  in  1  reset; asynchronous, active-low
- A  in  W  operand A, unsigned
- B  in  W  operand B, unsigned
- ALU_FUN  in  4  function select
- Arith_OUT  out  2W  arithmetic result
- Carry_OUT  out  1  arithmetic carry/borrow
- Arith_FLAG  out  1  arithmetic unit selected last cycle
- Logic_OUT  out  W  logic result
- Logic_FLAG  out  1  logic unit selected
- Shift_OUT  out  W  shift result
- Shift_FLAG  out  1  shift unit selected
- CMP_OUT  out  3  compare result
- CMP_FLAG  out  1  compare unit selected

Behaviour:
- Reset (RST=0, asynchronous): every output is 0 and held at 0 while RST is low. The first capture happens on the first rising edge after RST goes high.
- Latency is 1 cycle. Inputs are sampled at a CLK rising edge, and outputs are valid after that edge and held until the next edge. There is no handshake; a new operation can be issued every cycle.
- Decode on ALU_FUN[3:2]:
  - 00 arithmetic
  - 01 logic
  - 10 compare
  - 11 shift
- Only the selected unit's flag is 1, and the other three flags are 0, so exactly one flag is high after any post-reset edge.
- Every non-selected unit's result register (and Carry_OUT, when arithmetic is not selected) is cleared to 0 on that edge.
- Arithmetic (ALU_FUN[1:0]):
  - 00: Arith_OUT = A+B, zero-extended to 2W. Carry_OUT = bit W of the sum.
  - 01: Arith_OUT = A-B as 2W-bit two's complement. Carry_OUT = 1 if A<B (borrow), else 0.
  - 10: Arith_OUT = A*B, full 2W product. Carry_OUT = 0.
  - 11: Arith_OUT = A/B, unsigned integer quotient, zero-extended. Carry_OUT = 0. If B=0, Arith_OUT = 0.
- Logic: 00 A&B; 01 A|B; 10 ~(A&B); 11 ~(A|B).
- Compare (CMP_OUT):
  - 00: always 0
  - 01: 3'd1 if A==B, else 0
  - 10: 3'd2 if A>B, else 0
  - 11: 3'd3 if A<B, else 0
- Shift (logical, zero fill, W-bit result, shifted-out bit discarded): 00 A>>1; 01 A<<1; 10 B>>1; 11 B<<1.
- Reset asserted mid-operation clears all outputs immediately, without waiting for a clock edge.

Optional Feature:
- Macro ALU_DIVIDER_EN.
- Defined: function 0011 performs unsigned division as specified above.
- Not defined: no divider is synthesised. Function 0011 yields Arith_OUT=0 and Carry_OUT=0, and Arith_FLAG is still 1.
- All other functions behave identically in both builds.

Test Plan:
All scenarios use W=16 with ALU_DIVIDER_EN defined. "Flags" is the vector {Carry_OUT, Arith_FLAG, Logic_FLAG, CMP_FLAG, Shift_FLAG}.
- RST=0, A=15, B=10, FUN=0000 → all outputs 0 before and after clock edges; Flags=0.
- RST=1, then the arithmetic set; each check is one edge after its stimulus:
  - FUN=0000, A=15, B=10 → Arith_OUT=25, Flags=5'b01000
  - FUN=0001, A=15, B=10 → Arith_OUT=5, Flags=5'b01000
  - FUN=0010, A=2, B=2 → Arith_OUT=4
  - FUN=0011, A=2, B=2 → Arith_OUT=1
  - FUN=0011, B=0 → Arith_OUT=0
  - FUN=0000, A=B=16'hFFFF → Arith_OUT=32'h1FFFE, Carry_OUT=1
- Logic set (Logic_FLAG only, Flags=5'b00100; Arith_OUT returns to 0):
  - FUN=0100, A=2, B=2 → 2
  - FUN=0101, A=3, B=2 → 3
  - FUN=0110, A=B=1 → 16'hFFFE
  - FUN=0111, A=B=1 → 16'hFFFE
- Compare set (Flags=5'b00010):
  - FUN=1000, A=B=1 → 0
  - FUN=1001, A=B=1 → 1
  - FUN=1010, A=3, B=2 → 2
  - FUN=1011, A=2, B=3 → 3
  - FUN=1011, A=3, B=2 → 0
- Shift set (Flags=5'b00001):
  - FUN=1100, A=2 → 1
  - FUN=1101, A=2 → 4
  - FUN=1110, B=2 → 1
  - FUN=1111, B=2 → 4
  - FUN=1101, A=16'h8000 → 0
- Pull RST low asynchronously mid-cycle while the shift result is non-zero → all outputs 0 immediately, before the next CLK edge.
